// File: rtl/ds_link_pkg.sv
// Shared definitions for the IEEE1355 data-strobe link transmitter.
// Holds the FSM state encoding, the default NULL character and counter-width helpers.
package ds_link_pkg;

  typedef logic [1:0] ds_state_t;

  localparam ds_state_t StIdle  = 2'd0;
  localparam ds_state_t StLoad  = 2'd1;
  localparam ds_state_t StShift = 2'd2;

  localparam logic [9:0] DefaultNullCode = 10'b0111010000;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ds_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// Writes are dropped when full and reads are ignored when empty.
module ds_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [Width-1:0]         wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [Width-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(Depth):0]   level
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned LW = AW + 1;

  logic [Width-1:0] mem [Depth];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             wr_fire, rd_fire;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == LW'(Depth));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr_q[AW-1:0]];
  assign wr_fire = wr_en & ~full;
  assign rd_fire = rd_en & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ds_link_tx.sv
// IEEE1355 data-strobe transmitter: buffers characters in a FIFO and serialises them
// onto D/S at G_CLK_DIV clocks per bit, optionally filling idle time with NULL characters.
module ds_link_tx
  import ds_link_pkg::*;
#(
  parameter int unsigned            G_CHAR_BITS  = 10,
  parameter int unsigned            G_CLK_DIV    = 4,
  parameter int unsigned            G_FIFO_DEPTH = 8,
  parameter int unsigned            G_LSB_FIRST  = 1,
  parameter int unsigned            G_IDLE_MODE  = 0,
  parameter logic [G_CHAR_BITS-1:0] G_NULL_CODE  = G_CHAR_BITS'(DefaultNullCode)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [G_CHAR_BITS-1:0]        tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          enable,
  output logic                          D,
  output logic                          S,
  output logic                          busy,
  output logic [$clog2(G_FIFO_DEPTH):0] fill_level,
  output logic [15:0]                   sent_count
);

  localparam int unsigned TW = cnt_width(G_CLK_DIV);
  localparam int unsigned BW = cnt_width(G_CHAR_BITS);

  ds_state_t              state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [G_CHAR_BITS-1:0] shift_q, shift_d;
  logic                   is_data_q, is_data_d;
  logic                   d_q, d_d;
  logic                   s_q, s_d;
  logic                   done_q, done_d;
  logic [15:0]            sent_count_q;

  logic                   fifo_rd, fifo_full, fifo_empty;
  logic [G_CHAR_BITS-1:0] fifo_rd_data;
  logic                   char_avail, start, advance, next_bit;

  ds_fifo #(
    .Width (G_CHAR_BITS),
    .Depth (G_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (tx_valid & tx_ready),
    .wr_data (tx_data),
    .full    (fifo_full),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .level   (fill_level)
  );

  // Bit that goes on the line first for a freshly loaded or just-shifted register.
  function automatic logic lead_bit(input logic [G_CHAR_BITS-1:0] c);
    return (G_LSB_FIRST != 0) ? c[0] : c[G_CHAR_BITS-1];
  endfunction

  assign char_avail = ~fifo_empty | (G_IDLE_MODE != 0);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    is_data_d = is_data_q;
    d_d       = d_q;
    s_d       = s_q;
    done_d    = 1'b0;
    fifo_rd   = 1'b0;
    start     = 1'b0;
    advance   = 1'b0;
    next_bit  = d_q;

    case (state_q)
      StIdle: begin
        if (enable && char_avail) state_d = StLoad;
      end
      StLoad: begin
        start = 1'b1;
      end
      StShift: begin
        if (timer_q == TW'(G_CLK_DIV - 1)) begin
          timer_d = '0;
          if (bit_cnt_q == BW'(G_CHAR_BITS - 1)) begin
            done_d = is_data_q;
            // Reload on the same edge so consecutive characters have no gap.
            if (enable && char_avail) start = 1'b1;
            else                      state_d = StIdle;
          end else begin
            advance = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      shift_d   = (G_LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);
      bit_cnt_d = bit_cnt_q + 1'b1;
      next_bit  = lead_bit(shift_d);
    end

    if (start) begin
      fifo_rd   = ~fifo_empty;
      shift_d   = fifo_empty ? G_NULL_CODE : fifo_rd_data;
      is_data_d = ~fifo_empty;
      bit_cnt_d = '0;
      timer_d   = '0;
      state_d   = StShift;
      next_bit  = lead_bit(shift_d);
    end

    // Strobe toggles only when data repeats, so exactly one line changes per bit.
    if (advance || start) begin
      d_d = next_bit;
      s_d = (next_bit == d_q) ? ~s_q : s_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      is_data_q    <= 1'b0;
      d_q          <= 1'b0;
      s_q          <= 1'b0;
      done_q       <= 1'b0;
      sent_count_q <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      is_data_q    <= is_data_d;
      d_q          <= d_d;
      s_q          <= s_d;
      done_q       <= done_d;
      sent_count_q <= sent_count_q + {15'd0, done_q};
    end
  end

  assign tx_ready   = ~fifo_full;
  assign D          = d_q;
  assign S          = s_q;
  assign busy       = (state_q != StIdle);
  assign sent_count = sent_count_q;

endmodule

// File: tb/tb_ds_link_tx.sv
// Directed bench for ds_link_tx: one hold-mode and one NULL-fill instance, each watched by
// a small DS line decoder that rebuilds characters and checks every bit lasts four clocks.
module tb_ds_link_tx;

  localparam logic [9:0] NullCode = 10'b0111010000;

  typedef struct {
    logic [9:0] data;
    logic [9:0] order;  // bits in line order, first-sent at [9]
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  tx_data, tx_data_n;
  logic        tx_valid, tx_valid_n, enable, enable_n;
  logic        tx_ready, tx_ready_n, d0, s0, d1, s1, busy, busy_n;
  logic [3:0]  fill, fill_n;
  logic [15:0] sent, sent_n;

  int n_vec = 0;
  int n_err = 0;
  logic [9:0] rxq0[$];
  logic [9:0] rxq1[$];

  always #5 clk = ~clk;

  ds_link_tx #(
    .G_CHAR_BITS (10), .G_CLK_DIV (4), .G_FIFO_DEPTH (8),
    .G_LSB_FIRST (1), .G_IDLE_MODE (0), .G_NULL_CODE (NullCode)
  ) dut (
    .clk (clk), .rst_n (rst_n), .tx_data (tx_data), .tx_valid (tx_valid),
    .tx_ready (tx_ready), .enable (enable), .D (d0), .S (s0), .busy (busy),
    .fill_level (fill), .sent_count (sent)
  );

  ds_link_tx #(
    .G_CHAR_BITS (10), .G_CLK_DIV (4), .G_FIFO_DEPTH (8),
    .G_LSB_FIRST (1), .G_IDLE_MODE (1), .G_NULL_CODE (NullCode)
  ) dut_n (
    .clk (clk), .rst_n (rst_n), .tx_data (tx_data_n), .tx_valid (tx_valid_n),
    .tx_ready (tx_ready_n), .enable (enable_n), .D (d1), .S (s1), .busy (busy_n),
    .fill_level (fill_n), .sent_count (sent_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // DS decoder: a bit is present whenever D^S changes; LSB-first framing from reset.
  logic       par [2];
  int         gap [2];
  int         bidx [2];
  logic [9:0] rsh [2];

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      logic dv, sv;
      dv = (u == 0) ? d0 : d1;
      sv = (u == 0) ? s0 : s1;
      if (!rst_n) begin
        par[u]  = 1'b0;
        gap[u]  = 0;
        bidx[u] = 0;
        rsh[u]  = '0;
        if (u == 0) rxq0.delete();
        else        rxq1.delete();
      end else begin
        gap[u]++;
        if ((dv ^ sv) != par[u]) begin
          par[u] = dv ^ sv;
          if (bidx[u] != 0) check((u == 0) ? "bit_period" : "bit_period_n", gap[u], 4);
          gap[u] = 0;
          rsh[u] = {dv, rsh[u][9:1]};
          bidx[u]++;
          if (bidx[u] == 10) begin
            if (u == 0) rxq0.push_back(rsh[u]);
            else        rxq1.push_back(rsh[u]);
            bidx[u] = 0;
          end
        end
      end
    end
  end

  // Returns at the negedge just after the accepting clock edge.
  task automatic write_dut(input logic [9:0] data);
    @(negedge clk);
    tx_data  = data;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [15:0] prev;
    prev = sent;
    write_dut(v.data);
    check({tag, "_busy_k"}, busy, 1'b0);
    @(negedge clk);
    check({tag, "_busy_k1"}, busy, 1'b1);
    @(negedge clk);
    check({tag, "_bit0"}, d0, v.order[9]);
    for (int i = 1; i < 10; i++) begin
      repeat (4) @(negedge clk);
      check({tag, "_bit", $sformatf("%0d", i)}, d0, v.order[9-i]);
    end
    repeat (4) @(negedge clk);
    check({tag, "_busy_end"}, busy, 1'b0);
    check({tag, "_cnt_before"}, sent, prev);
    @(negedge clk);
    check({tag, "_cnt_after"}, sent, 16'(prev + 16'd1));
    check({tag, "_rx_size"}, rxq0.size(), 1);
    if (rxq0.size() > 0) check({tag, "_rx_data"}, rxq0.pop_front(), v.data);
  endtask

  initial begin
    vec_t        vt [6];
    logic [9:0]  bd [9];
    logic [9:0]  exp_n [5];
    logic [15:0] base;
    logic        ok, dh, sh;

    vt[0] = '{data: 10'b1111000011, order: 10'b1100001111};
    vt[1] = '{data: 10'h000,        order: 10'h000};
    vt[2] = '{data: 10'h3FF,        order: 10'h3FF};
    vt[3] = '{data: 10'b0011001100, order: 10'b0011001100};
    vt[4] = '{data: 10'b0000000001, order: 10'b1000000000};
    vt[5] = '{data: 10'h2AA,        order: 10'h155};
    exp_n = '{NullCode, NullCode, NullCode, 10'h3CC, NullCode};
    for (int i = 0; i < 9; i++) bd[i] = 10'((i * 73 + 17) % 1024);

    tx_data = '0; tx_valid = 1'b0; enable = 1'b0;
    tx_data_n = '0; tx_valid_n = 1'b0; enable_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_D", d0, 1'b0);
    check("rst_S", s0, 1'b0);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_fill", fill, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_sent", sent, 16'd0);
    check("rst_busy_n", busy_n, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // NULL fill with a data character written mid-NULL
    @(negedge clk);
    enable_n = 1'b1;
    repeat (100) @(negedge clk);
    check("null_cnt_idle", sent_n, 16'd0);
    check("null_busy", busy_n, 1'b1);
    tx_data_n = 10'h3CC;
    tx_valid_n = 1'b1;
    @(negedge clk);
    tx_valid_n = 1'b0;
    check("null_fill", fill_n, 4'd1);
    repeat (99) @(negedge clk);
    enable_n = 1'b0;
    check("null_cnt_data", sent_n, 16'd1);
    repeat (60) @(negedge clk);
    check("null_busy_off", busy_n, 1'b0);
    check("null_rx_size", rxq1.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < rxq1.size()) check($sformatf("null_rx%0d", i), rxq1[i], exp_n[i]);
    check("null_cnt_final", sent_n, 16'd1);

    // Single characters, table driven
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Burst of nine: fill to full, then drain contiguously
    base = sent;
    enable = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      tx_data = bd[i];
      tx_valid = 1'b1;
    end
    check("burst_full", fill, 4'd8);
    check("burst_ready0", tx_ready, 1'b0);
    repeat (3) @(negedge clk);
    check("burst_hold", fill, 4'd8);
    enable = 1'b1;
    @(negedge clk);
    check("burst_busy", busy, 1'b1);
    @(negedge clk);
    check("burst_pop", fill, 4'd7);
    check("burst_ready1", tx_ready, 1'b1);
    @(negedge clk);
    check("burst_refill", fill, 4'd8);
    tx_valid = 1'b0;
    ok = 1'b1;
    for (int j = 3; j <= 360; j++) begin
      @(negedge clk);
      if (!busy) ok = 1'b0;
    end
    check("burst_contig", ok, 1'b1);
    check("burst_cnt8", sent, 16'(base + 16'd8));
    @(negedge clk);
    check("burst_idle", busy, 1'b0);
    @(negedge clk);
    check("burst_cnt9", sent, 16'(base + 16'd9));
    check("burst_rx_size", rxq0.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < rxq0.size()) check($sformatf("burst_rx%0d", i), rxq0[i], bd[i]);
    rxq0.delete();

    // enable dropped during bit 5: character completes, lines freeze, queue kept
    base = sent;
    write_dut(10'b1111000011);
    write_dut(10'h0F0);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    repeat (19) @(negedge clk);
    check("en_busy_last", busy, 1'b1);
    @(negedge clk);
    check("en_busy_off", busy, 1'b0);
    check("en_fill", fill, 4'd1);
    check("en_D_last", d0, 1'b1);
    dh = d0;
    sh = s0;
    repeat (20) @(negedge clk);
    check("en_D_hold", d0, dh);
    check("en_S_hold", s0, sh);
    check("en_still_idle", busy, 1'b0);
    check("en_cnt", sent, 16'(base + 16'd1));
    check("en_rx_a", (rxq0.size() > 0) ? rxq0.pop_front() : 10'h000, 10'b1111000011);
    enable = 1'b1;
    repeat (50) @(negedge clk);
    check("en_drain_fill", fill, 4'd0);
    check("en_cnt2", sent, 16'(base + 16'd2));
    check("en_rx_b", (rxq0.size() > 0) ? rxq0.pop_front() : 10'h000, 10'h0F0);

    // Reset in the middle of a character
    write_dut(10'h3FF);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_D", d0, 1'b0);
    check("mrst_S", s0, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_fill", fill, 4'd0);
    check("mrst_ready", tx_ready, 1'b1);
    check("mrst_sent", sent, 16'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_vec(vt[3], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
